// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mips_pkg                                                    |
// | Brief  : Shared types and constants for the MIPS pipeline MEM stage: |
// |          access FSM state encoding, datapath widths and the default  |
// |          data-memory base address.                                   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int DEST_W = 5;

    // Byte address at which the data memory window starts.
    localparam logic [XLEN-1:0] BASE_ADDR_DEFAULT = 32'd1024;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mem_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_stage_reg                                               |
// | Brief  : MEM/WB pipeline register. freeze inserts a bubble (wb_en=0) |
// |          and holds the remaining fields; mem_data has its own load   |
// |          strobe because it only changes when a memory access ends.   |
// | Ports  : clk, rst (sync, active-high), freeze, data_load, data_in,   |
// |          *_in fields from EXE/MEM, registered MEM/WB outputs.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mem_stage_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              data_load,
    input  logic [XLEN-1:0]   data_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [XLEN-1:0]   alu_result,
    output logic [XLEN-1:0]   mem_data,
    output logic [DEST_W-1:0] dest
);

    logic              wb_en_q,      wb_en_d;
    logic              mem_r_en_q,   mem_r_en_d;
    logic [XLEN-1:0]   alu_result_q, alu_result_d;
    logic [XLEN-1:0]   mem_data_q,   mem_data_d;
    logic [DEST_W-1:0] dest_q,       dest_d;

    always_comb begin
        wb_en_d      = wb_en_q;
        mem_r_en_d   = mem_r_en_q;
        alu_result_d = alu_result_q;
        mem_data_d   = mem_data_q;
        dest_d       = dest_q;

        if (freeze) begin
            // Stalled instruction must not retire twice: emit a bubble.
            wb_en_d = 1'b0;
        end else begin
            wb_en_d      = wb_en_in;
            mem_r_en_d   = mem_r_en_in;
            alu_result_d = alu_result_in;
            dest_d       = dest_in;
        end

        if (data_load) begin
            mem_data_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
        end else begin
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            dest_q       <= dest_d;
        end
    end

    assign wb_en      = wb_en_q;
    assign mem_r_en   = mem_r_en_q;
    assign alu_result = alu_result_q;
    assign mem_data   = mem_data_q;
    assign dest       = dest_q;

endmodule : mem_stage_reg
`default_nettype wire

// File: rtl/mem_stage_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_stage_access_ctrl                                       |
// | Brief  : MEM stage of the 5-stage MIPS pipeline. Issues req/ack      |
// |          accesses to a multi-cycle data memory, stalls upstream with |
// |          freeze while an access is outstanding, aborts accesses that |
// |          exceed TIMEOUT cycles (sticky err) and holds the MEM/WB     |
// |          pipeline register.                                          |
// | Ports  : clk, rst (sync, active-high); EXE/MEM inputs *_in;          |
// |          memory port mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/    |
// |          mem_ack; freeze; MEM/WB outputs wb_en/mem_r_en/alu_result/  |
// |          mem_data/dest; err.                                         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mem_stage_access_ctrl
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int              ADDR_W    = 16,
    parameter int              TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [XLEN-1:0]   st_val_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              freeze,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [XLEN-1:0]   alu_result,
    output logic [XLEN-1:0]   mem_data,
    output logic [DEST_W-1:0] dest,
    output logic              err
);

    // One spare bit so TIMEOUT=1 still yields a legal counter width.
    localparam int              CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             err_q,   err_d;

    logic             access;
    logic             is_busy;
    logic             timeout_hit;
    logic             data_load;
    logic [XLEN-1:0]  data_in;
    logic [XLEN-1:0]  addr_off;
    logic             unused_addr_bits;

    assign access  = mem_r_en_in | mem_w_en_in;
    assign is_busy = (state_q == ST_BUSY);

    // An ack in the final allowed cycle wins over the abort.
    assign timeout_hit = is_busy & ~mem_ack & (cnt_q == CNT_LAST);

    // Byte offset into the memory window, converted to a word address.
    // Underflow below BASE_ADDR simply wraps.
    assign addr_off         = alu_result_in - BASE_ADDR;
    assign mem_addr         = addr_off[ADDR_W+1:2];
    assign unused_addr_bits = ^addr_off;

    // The memory port is driven straight from EXE/MEM; freeze keeps
    // those inputs stable for the whole access.
    assign mem_req   = is_busy | access;
    assign mem_we    = mem_w_en_in;
    assign mem_wdata = st_val_in;

    assign freeze = (~is_busy & access) | (is_busy & ~mem_ack & ~timeout_hit);

    // Reads capture the returned word; a read+write pair behaves as a
    // write and clears mem_data; an abort also clears it.
    assign data_load = (is_busy & mem_ack & mem_r_en_in) | timeout_hit;
    assign data_in   = (timeout_hit | mem_w_en_in) ? '0 : mem_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | timeout_hit;

        case (state_q)
            ST_IDLE: begin
                // Counter parked at zero so it starts clean on BUSY entry.
                cnt_d = '0;
                if (access) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    mem_stage_reg u_mem_stage_reg (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .data_load     (data_load),
        .data_in       (data_in),
        .wb_en_in      (wb_en_in),
        .mem_r_en_in   (mem_r_en_in),
        .alu_result_in (alu_result_in),
        .dest_in       (dest_in),
        .wb_en         (wb_en),
        .mem_r_en      (mem_r_en),
        .alu_result    (alu_result),
        .mem_data      (mem_data),
        .dest          (dest)
    );

endmodule : mem_stage_access_ctrl
`default_nettype wire
